// File: rtl/player_mover.sv
// -----------------------------------------------------------------------------
// player_mover
//
// Movement engine for NPLAYERS sprites. Once every FRAME_DIV frames (counted
// on rising edges of EOF) each player's direction buttons are sampled, the
// sprite's top-left corner is stepped by STEP pixels on each axis that has a
// net direction, and the result is clamped to the HACTIVE x VACTIVE active
// area so the whole sprite stays on screen. Facing and moving status are
// reported per player for sprite animation.
//
// Optional feature: define PLAYER_COLLISION_EN to stop players from moving
// into each other. Without it, players pass through each other and no
// comparison logic is built.
//
// Ports
//   clk         pixel clock
//   reset       synchronous, active-high reset
//   EOF         end-of-frame level from the timing generator
//   up/down/left/right [NPLAYERS]   buttons, player i on bit i
//   x_pos/y_pos [NPLAYERS*COORD_W]  player i on [i*COORD_W +: COORD_W]
//   facing [2*NPLAYERS]             per player: 0=down 1=up 2=left 3=right
//   moving [NPLAYERS]               player moved at the last update
//   frame_tick                      one-cycle pulse on each EOF rising edge
// -----------------------------------------------------------------------------
module player_mover #(
  parameter int NPLAYERS  = 2,
  parameter int COORD_W   = 11,
  parameter int HACTIVE   = 800,
  parameter int VACTIVE   = 600,
  parameter int SPRITE    = 32,
  parameter int STEP      = 2,
  parameter int FRAME_DIV = 1,
  parameter int START_X   = 32,
  parameter int START_Y   = 32,
  parameter int START_DX  = 704
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          EOF,
  input  logic [NPLAYERS-1:0]           up,
  input  logic [NPLAYERS-1:0]           down,
  input  logic [NPLAYERS-1:0]           left,
  input  logic [NPLAYERS-1:0]           right,
  output logic [NPLAYERS*COORD_W-1:0]   x_pos,
  output logic [NPLAYERS*COORD_W-1:0]   y_pos,
  output logic [2*NPLAYERS-1:0]         facing,
  output logic [NPLAYERS-1:0]           moving,
  output logic                          frame_tick
);

  // One extra bit of headroom so add/subtract never wraps before clamping.
  localparam int CW1 = COORD_W + 1;
  typedef logic [CW1-1:0]     wide_t;
  typedef logic [COORD_W-1:0] coord_t;

  localparam wide_t  X_MAX_W  = wide_t'(HACTIVE - SPRITE);
  localparam wide_t  Y_MAX_W  = wide_t'(VACTIVE - SPRITE);
  localparam coord_t X_MAX_N  = coord_t'(HACTIVE - SPRITE);
  localparam coord_t Y_MAX_N  = coord_t'(VACTIVE - SPRITE);
  localparam wide_t  STEP_W   = wide_t'(STEP);

  localparam logic [1:0] FACE_DOWN  = 2'd0;
  localparam logic [1:0] FACE_UP    = 2'd1;
  localparam logic [1:0] FACE_LEFT  = 2'd2;
  localparam logic [1:0] FACE_RIGHT = 2'd3;

  localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

  // ---------------------------------------------------------------------------
  // Frame detection and update divider
  // ---------------------------------------------------------------------------
  logic             eof_q_reg;
  logic [CNT_W-1:0] count_reg;
  logic             tick;
  logic             update;

  assign tick       = EOF & ~eof_q_reg;
  assign update     = tick & (count_reg == CNT_LAST);
  assign frame_tick = tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      eof_q_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      eof_q_reg <= EOF;
      if (tick) begin
        count_reg <= (count_reg == CNT_LAST) ? '0 : count_reg + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Player state
  // ---------------------------------------------------------------------------
  coord_t     x_reg      [NPLAYERS];
  coord_t     y_reg      [NPLAYERS];
  logic [1:0] facing_reg [NPLAYERS];
  logic [NPLAYERS-1:0] moving_reg;

  // Net direction per axis: opposing buttons cancel.
  logic [NPLAYERS-1:0] h_neg, h_pos, v_neg, v_pos;
  assign h_neg = left  & ~right;
  assign h_pos = right & ~left;
  assign v_neg = up    & ~down;
  assign v_pos = down  & ~up;

  // Tentative (wall-clamped) positions, ignoring other players.
  coord_t tx [NPLAYERS];
  coord_t ty [NPLAYERS];

  always_comb begin
    for (int i = 0; i < NPLAYERS; i++) begin
      tx[i] = x_reg[i];
      ty[i] = y_reg[i];
      if (h_neg[i]) begin
        tx[i] = ({1'b0, x_reg[i]} < STEP_W) ? '0
                                             : coord_t'({1'b0, x_reg[i]} - STEP_W);
      end else if (h_pos[i]) begin
        tx[i] = ({1'b0, x_reg[i]} > (X_MAX_W - STEP_W)) ? X_MAX_N
                                             : coord_t'({1'b0, x_reg[i]} + STEP_W);
      end
      if (v_neg[i]) begin
        ty[i] = ({1'b0, y_reg[i]} < STEP_W) ? '0
                                             : coord_t'({1'b0, y_reg[i]} - STEP_W);
      end else if (v_pos[i]) begin
        ty[i] = ({1'b0, y_reg[i]} > (Y_MAX_W - STEP_W)) ? Y_MAX_N
                                             : coord_t'({1'b0, y_reg[i]} + STEP_W);
      end
    end
  end

  // Final positions after optional player-player blocking.
  coord_t fx [NPLAYERS];
  coord_t fy [NPLAYERS];

`ifdef PLAYER_COLLISION_EN
  localparam coord_t SPRITE_N = coord_t'(SPRITE);

  // Two SPRITE boxes overlap when both separations are strictly below SPRITE;
  // touching edges (separation == SPRITE) is allowed.
  function automatic logic boxes_overlap(input coord_t ax, input coord_t ay,
                                         input coord_t bx, input coord_t by);
    coord_t dx;
    coord_t dy;
    dx = (ax > bx) ? ax - bx : bx - ax;
    dy = (ay > by) ? ay - by : by - ay;
    return (dx < SPRITE_N) && (dy < SPRITE_N);
  endfunction

  logic [NPLAYERS-1:0] block_x, block_y;

  // Every decision uses pre-update positions and other players' unblocked
  // tentative moves, so the outcome is independent of player index order.
  // Each axis is tested on its own so a blocked diagonal can still slide.
  always_comb begin
    block_x = '0;
    block_y = '0;
    for (int i = 0; i < NPLAYERS; i++) begin
      for (int j = 0; j < NPLAYERS; j++) begin
        if (i != j) begin
          if (boxes_overlap(tx[i], y_reg[i], x_reg[j], y_reg[j]) ||
              boxes_overlap(tx[i], y_reg[i], tx[j],    ty[j])) begin
            block_x[i] = 1'b1;
          end
          if (boxes_overlap(x_reg[i], ty[i], x_reg[j], y_reg[j]) ||
              boxes_overlap(x_reg[i], ty[i], tx[j],    ty[j])) begin
            block_y[i] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NPLAYERS; i++) begin
      fx[i] = block_x[i] ? x_reg[i] : tx[i];
      fy[i] = block_y[i] ? y_reg[i] : ty[i];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NPLAYERS; i++) begin
      fx[i] = tx[i];
      fy[i] = ty[i];
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // State update: only on update; everything holds between updates.
  // Facing follows the requested direction even when blocked, so a player
  // pushing into a wall or another player turns but reports moving=0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NPLAYERS; i++) begin
        x_reg[i]      <= coord_t'(START_X + i * START_DX);
        y_reg[i]      <= coord_t'(START_Y);
        facing_reg[i] <= FACE_DOWN;
      end
      moving_reg <= '0;
    end else if (update) begin
      for (int i = 0; i < NPLAYERS; i++) begin
        x_reg[i]      <= fx[i];
        y_reg[i]      <= fy[i];
        moving_reg[i] <= (fx[i] != x_reg[i]) || (fy[i] != y_reg[i]);
        // Horizontal takes priority over vertical on a diagonal.
        if (h_neg[i]) begin
          facing_reg[i] <= FACE_LEFT;
        end else if (h_pos[i]) begin
          facing_reg[i] <= FACE_RIGHT;
        end else if (v_neg[i]) begin
          facing_reg[i] <= FACE_UP;
        end else if (v_pos[i]) begin
          facing_reg[i] <= FACE_DOWN;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output packing
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NPLAYERS; gi++) begin : g_pack
      assign x_pos[gi*COORD_W +: COORD_W] = x_reg[gi];
      assign y_pos[gi*COORD_W +: COORD_W] = y_reg[gi];
      assign facing[2*gi +: 2]            = facing_reg[gi];
    end
  endgenerate

  assign moving = moving_reg;

endmodule

// File: tb/tb_player_mover.sv
// -----------------------------------------------------------------------------
// tb_player_mover
//
// Directed bench for player_mover. Instance A uses default parameters;
// instance B uses FRAME_DIV=4 with P0 starting next to the left and bottom
// edges. With PLAYER_COLLISION_EN defined, instances C and D place two
// players close together to exercise blocking.
// -----------------------------------------------------------------------------
module tb_player_mover;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ticks_a  = 0;
  int ticks_b  = 0;
  int t0;

  // Instance A: defaults
  logic        reset_a, eof_a, ft_a;
  logic [1:0]  up_a, down_a, left_a, right_a, moving_a;
  logic [21:0] x_a, y_a;
  logic [3:0]  facing_a;

  // Instance B: FRAME_DIV=4, P0 starts at (1,567)
  logic        reset_b, eof_b, ft_b;
  logic [1:0]  up_b, down_b, left_b, right_b, moving_b;
  logic [21:0] x_b, y_b;
  logic [3:0]  facing_b;

  // Collision instances share reset/EOF
  logic        reset_c, eof_c;

  player_mover dut_a (
    .clk(clk), .reset(reset_a), .EOF(eof_a),
    .up(up_a), .down(down_a), .left(left_a), .right(right_a),
    .x_pos(x_a), .y_pos(y_a), .facing(facing_a), .moving(moving_a),
    .frame_tick(ft_a)
  );

  player_mover #(.FRAME_DIV(4), .START_X(1), .START_Y(567)) dut_b (
    .clk(clk), .reset(reset_b), .EOF(eof_b),
    .up(up_b), .down(down_b), .left(left_b), .right(right_b),
    .x_pos(x_b), .y_pos(y_b), .facing(facing_b), .moving(moving_b),
    .frame_tick(ft_b)
  );

`ifdef PLAYER_COLLISION_EN
  logic [1:0]  left_c, right_c, right_d, moving_c, moving_d, zero2;
  logic [21:0] x_c, y_c, x_d, y_d;
  logic [3:0]  facing_c, facing_d;
  logic        ft_c, ft_d;

  player_mover #(.START_X(100), .START_Y(100), .START_DX(34)) dut_c (
    .clk(clk), .reset(reset_c), .EOF(eof_c),
    .up(zero2), .down(zero2), .left(left_c), .right(right_c),
    .x_pos(x_c), .y_pos(y_c), .facing(facing_c), .moving(moving_c),
    .frame_tick(ft_c)
  );

  player_mover #(.START_X(100), .START_Y(100), .START_DX(32)) dut_d (
    .clk(clk), .reset(reset_c), .EOF(eof_c),
    .up(zero2), .down(zero2), .left(zero2), .right(right_d),
    .x_pos(x_d), .y_pos(y_d), .facing(facing_d), .moving(moving_d),
    .frame_tick(ft_d)
  );
`endif

  always @(posedge clk) begin
    if (ft_a === 1'b1) ticks_a++;
    if (ft_b === 1'b1) ticks_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Raise EOF on one instance for 'hi' cycles, then leave it low long enough
  // for the registered outputs to settle.
  task automatic pulse(input int which, input int hi);
    @(negedge clk);
    case (which)
      0: eof_a = 1'b1;
      1: eof_b = 1'b1;
      default: eof_c = 1'b1;
    endcase
    repeat (hi) @(negedge clk);
    eof_a = 1'b0;
    eof_b = 1'b0;
    eof_c = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    eof_a = 0; up_a = 0; down_a = 0; left_a = 0; right_a = 0;
    eof_b = 0; up_b = 0; down_b = 0; left_b = 0; right_b = 0;
    eof_c = 0;
`ifdef PLAYER_COLLISION_EN
    left_c = 0; right_c = 0; right_d = 0; zero2 = 0;
`endif
    reset_a = 1; reset_b = 1; reset_c = 1;
    repeat (3) @(negedge clk);
    reset_a = 0; reset_b = 0; reset_c = 0;
    @(negedge clk);

    // Reset state
    check("rst_x0", x_a[10:0], 32);
    check("rst_y0", y_a[10:0], 32);
    check("rst_x1", x_a[21:11], 736);
    check("rst_y1", y_a[21:11], 32);
    check("rst_facing", facing_a, 0);
    check("rst_moving", moving_a, 0);
    check("rst_ftick", ft_a, 0);
    check("rst_b_x0", x_b[10:0], 1);
    check("rst_b_y0", y_b[10:0], 567);

    // P0 holds right for three frames
    right_a = 2'b01;
    t0 = ticks_a;
    repeat (3) pulse(0, 1);
    check("right_x0", x_a[10:0], 38);
    check("right_facing0", facing_a[1:0], 3);
    check("right_moving", moving_a, 2'b01);
    check("right_ticks", ticks_a - t0, 3);
    check("right_x1", x_a[21:11], 736);
    check("right_facing1", facing_a[3:2], 0);

    // Outputs stable between updates
    repeat (5) @(negedge clk);
    check("stable_x0", x_a[10:0], 38);
    check("stable_moving", moving_a, 2'b01);

    // Opposing buttons cancel; P1 left+right does nothing
    up_a = 2'b01; down_a = 2'b01; right_a = 2'b11; left_a = 2'b10;
    pulse(0, 1);
    check("cancel_x0", x_a[10:0], 40);
    check("cancel_y0", y_a[10:0], 32);
    check("cancel_facing", facing_a, 4'b0011);
    check("cancel_x1", x_a[21:11], 736);
    check("cancel_moving", moving_a, 2'b01);

    // Presses between updates are ignored
    up_a = 0; down_a = 0; right_a = 0; left_a = 2'b01;
    repeat (3) @(negedge clk);
    left_a = 0;
    pulse(0, 1);
    check("ignore_x0", x_a[10:0], 40);
    check("ignore_moving", moving_a, 0);
    check("ignore_facing0", facing_a[1:0], 3);

    // Diagonal up-left: horizontal wins facing
    up_a = 2'b01; left_a = 2'b01;
    pulse(0, 1);
    check("diag_x0", x_a[10:0], 38);
    check("diag_y0", y_a[10:0], 30);
    check("diag_facing0", facing_a[1:0], 2);
    check("diag_moving", moving_a, 2'b01);

    // Reset coinciding with an update wins
    up_a = 0; left_a = 0;
    @(negedge clk);
    eof_a = 1; reset_a = 1; right_a = 2'b01;
    @(negedge clk);
    reset_a = 0; eof_a = 0; right_a = 0;
    @(negedge clk);
    check("rstupd_x0", x_a[10:0], 32);
    check("rstupd_y0", y_a[10:0], 30 + 2);
    check("rstupd_moving", moving_a, 0);
    check("rstupd_facing", facing_a, 0);

    // First EOF after reset updates normally
    right_a = 2'b01;
    pulse(0, 1);
    check("post_rst_x0", x_a[10:0], 34);
    right_a = 0;

    // Instance B: FRAME_DIV=4, long EOF highs, clamping at edges
    left_b = 2'b01; down_b = 2'b01;
    t0 = ticks_b;
    repeat (3) pulse(1, 10);
    check("fdiv_hold_x0", x_b[10:0], 1);
    check("fdiv_hold_y0", y_b[10:0], 567);
    check("fdiv_hold_ticks", ticks_b - t0, 3);
    pulse(1, 10);
    check("clamp_x0", x_b[10:0], 0);
    check("clamp_y0", y_b[10:0], 568);
    check("clamp_moving", moving_b, 2'b01);
    check("clamp_facing0", facing_b[1:0], 2);
    repeat (4) pulse(1, 10);
    check("wall_x0", x_b[10:0], 0);
    check("wall_y0", y_b[10:0], 568);
    check("wall_moving", moving_b, 0);
    check("wall_facing0", facing_b[1:0], 2);

    left_b = 0; down_b = 0; up_b = 2'b01;
    repeat (3) pulse(1, 10);
    check("up3_y0", y_b[10:0], 568);
    pulse(1, 10);
    check("up4_y0", y_b[10:0], 566);
    check("up4_facing0", facing_b[1:0], 1);
    repeat (3) pulse(1, 10);
    check("up7_y0", y_b[10:0], 566);
    pulse(1, 10);
    check("up8_y0", y_b[10:0], 564);
    check("b_ticks", ticks_b - t0, 16);
    up_b = 0;

`ifdef PLAYER_COLLISION_EN
    // C: P0 right, P1 left, tentative boxes overlap -> both blocked
    // D: P0 right toward idle P1 at distance 32 -> blocked
    right_c = 2'b01; left_c = 2'b10; right_d = 2'b01;
    pulse(2, 1);
    check("coll_c_x0", x_c[10:0], 100);
    check("coll_c_x1", x_c[21:11], 134);
    check("coll_c_moving", moving_c, 0);
    check("coll_c_facing", facing_c, 4'b1011);
    check("coll_d_x0", x_d[10:0], 100);
    check("coll_d_x1", x_d[21:11], 132);
    check("coll_d_moving", moving_d, 0);
    check("coll_d_facing0", facing_d[1:0], 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
